// File: rtl/safecrack_pkg.sv
// safecrack_pkg: shared types and constants for the safe-cracking lock and its dialer
// Holds the one-hot dialer state encoding, LED/button constants and a code validity helper.
package safecrack_pkg;
    localparam int DIGITS = 3;
    localparam logic [7:0] LED_READY = 8'h01;
    localparam logic [7:0] LED_SUCCESS = 8'hFF;
    localparam logic [2:0] BTN_IDLE = 3'b111;
    typedef enum logic [5:0] {
        S_IDLE       = 6'b000001,
        S_WAIT_READY = 6'b000010,
        S_PRESS      = 6'b000100,
        S_GAP        = 6'b001000,
        S_CHECK      = 6'b010000,
        S_DONE       = 6'b100000
    } dial_state_t;
    function automatic logic has_invalid_digit(input logic [2*DIGITS-1:0] c);
        logic r;
        r = 1'b0;
        for (int i = 0; i < DIGITS; i++) r = r | (&c[2*i +: 2]);
        return r;
    endfunction
endpackage

// File: rtl/safecrack_timer.sv
// safecrack_timer: loadable down-counter that parks at zero
// Ports: clk, rst (async, active-high), load/load_val (reload), expired (count reads zero).
module safecrack_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);
    logic [W-1:0] count;
    always_ff @(posedge clk or posedge rst)
        if (rst) count <= '0;
        else if (load) count <= load_val;
        else if (count != '0) count <= count - 1'b1;
    assign expired = count == '0;
endmodule

// File: rtl/safecrack_dialer.sv
// safecrack_dialer: replays a 3-digit button code onto the lock and reports pass/fail
// Ports: clk, rst (async, active-high); start/code from the host; leds_green/led_red from the lock;
// btn (active-low) to the lock; busy/done/pass/fail/bad_code status to the host.
module safecrack_dialer
    import safecrack_pkg::*;
#(
    parameter int PRESS_CYCLES   = 500_000,
    parameter int GAP_CYCLES     = 500_000,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [5:0] code,
    input  logic [7:0] leds_green,
    input  logic       led_red,
    output logic [2:0] btn,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       fail,
    output logic       bad_code
);
    localparam int MAXC = (PRESS_CYCLES > GAP_CYCLES ? PRESS_CYCLES : GAP_CYCLES) > TIMEOUT_CYCLES
                        ? (PRESS_CYCLES > GAP_CYCLES ? PRESS_CYCLES : GAP_CYCLES) : TIMEOUT_CYCLES;
    localparam int TW = $clog2(MAXC) + 1;

    dial_state_t state;
    logic [5:0]  code_q;
    logic [1:0]  idx;
    logic [1:0]  nidx;
    logic [1:0]  ndig;
    logic [2:0]  press_btn;
    logic [TW-1:0] tmr_val;
    logic        tmr_load, expired, acc, bad_in, ready, go_wait, go_press0, go_gap, gap_end, more;

    // A start landing on the done cycle is dropped so a host cannot chain onto the pulse it is reading.
    assign acc       = start && !done;
    assign bad_in    = has_invalid_digit(code);
    assign ready     = leds_green == LED_READY && !led_red;
    assign go_wait   = state == S_IDLE && acc && !bad_in;
    assign go_press0 = state == S_WAIT_READY && ready;
    assign go_gap    = state == S_PRESS && expired;
    assign gap_end   = state == S_GAP && !led_red && expired;
    assign more      = idx < 2'(DIGITS - 1);
    assign tmr_load  = go_wait || go_press0 || go_gap || gap_end;
    // Timer holds N-1 so a state lasts exactly N cycles before the zero reading ends it.
    assign tmr_val   = go_gap ? TW'(GAP_CYCLES - 1)
                     : (go_press0 || (gap_end && more)) ? TW'(PRESS_CYCLES - 1)
                     : TW'(TIMEOUT_CYCLES - 1);
    // Button pattern for the digit about to be pressed, so btn is registered on entry to PRESS.
    assign nidx      = state == S_GAP ? idx + 2'd1 : 2'd0;
    assign ndig      = 2'(code_q >> {nidx, 1'b0});
    assign press_btn = ~(3'b001 << ndig);

    safecrack_timer #(.W(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            code_q   <= '0;
            idx      <= '0;
            btn      <= BTN_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            fail     <= 1'b0;
            bad_code <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (acc) begin
                    code_q   <= code;
                    busy     <= 1'b1;
                    pass     <= 1'b0;
                    fail     <= bad_in;
                    bad_code <= bad_in;
                    state    <= bad_in ? S_DONE : S_WAIT_READY;
                end
                S_WAIT_READY: if (ready) begin
                    idx   <= '0;
                    btn   <= press_btn;
                    state <= S_PRESS;
                end else if (expired) begin
                    fail  <= 1'b1;
                    state <= S_DONE;
                end
                S_PRESS: if (expired) begin
                    btn   <= BTN_IDLE;
                    state <= S_GAP;
                end
                S_GAP: if (led_red) begin
                    fail  <= 1'b1;
                    state <= S_DONE;
                end else if (expired) begin
                    idx   <= more ? nidx : idx;
                    btn   <= more ? press_btn : BTN_IDLE;
                    state <= more ? S_PRESS : S_CHECK;
                end
                S_CHECK: if (led_red || (leds_green != LED_SUCCESS && expired)) begin
                    fail  <= 1'b1;
                    state <= S_DONE;
                end else if (leds_green == LED_SUCCESS) begin
                    pass  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_safecrack_dialer.sv
// tb_safecrack_dialer: randomized and directed checks of the dialer against a behavioural lock with code 0,1,2
module tb_safecrack_dialer;
    localparam int P = 4;
    localparam int G = 4;
    localparam int T = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [5:0] code = '0;
    logic [7:0] leds_green;
    logic       led_red;
    logic [2:0] btn;
    logic       busy, done, pass, fail, bad_code;
    int n_tests = 0;
    int n_fail = 0;

    safecrack_dialer #(.PRESS_CYCLES(P), .GAP_CYCLES(G), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst(rst), .start(start), .code(code), .leds_green(leds_green), .led_red(led_red),
        .btn(btn), .busy(busy), .done(done), .pass(pass), .fail(fail), .bad_code(bad_code)
    );

    always #5 clk = ~clk;

    logic       lock_rst = 1'b1;
    logic       not_ready = 1'b0;
    int         prog = 0;
    logic       red = 1'b0;
    logic [2:0] prev_btn = 3'b111;

    always @(posedge clk)
        if (lock_rst) begin
            prog <= 0;
            red <= 1'b0;
            prev_btn <= 3'b111;
        end else begin
            prev_btn <= btn;
            if (prev_btn != 3'b111 && btn == 3'b111 && !red) begin
                if (prog < 3 && prev_btn == ~(3'b001 << prog)) prog <= prog + 1;
                else red <= 1'b1;
            end
        end

    assign leds_green = (not_ready || red) ? 8'h00 : prog == 3 ? 8'hFF : (8'h02 << prog) - 8'h01;
    assign led_red = red;

    logic [2:0] rv[$];
    int         rl[$];
    int         lat;
    bit         busy_drop;

    task automatic run_seq(input logic [5:0] c, input bit nr, input bit noise);
        lock_rst = 1'b1;
        not_ready = nr;
        rv.delete();
        rl.delete();
        busy_drop = 0;
        @(posedge clk);
        @(negedge clk);
        lock_rst = 1'b0;
        code = c;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        rv.push_back(btn);
        rl.push_back(1);
        while (!done && lat < 300) begin
            @(negedge clk);
            if (!busy) busy_drop = 1;
            start = noise && (lat % 5 == 2);
            code = noise ? 6'($urandom) : c;
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (btn == rv[rv.size()-1]) rl[rl.size()-1]++;
            else begin
                rv.push_back(btn);
                rl.push_back(1);
            end
        end
        n_tests++;
        if (!done) begin n_fail++; $display("FAIL done_timeout: done=%b after %0d cycles, required 1", done, lat); end
    endtask

    function automatic bit trace_ok(input logic [5:0] c, input int np);
        int k = 0;
        bit ok = 1;
        for (int i = 0; i < rv.size(); i++)
            if (rv[i] != 3'b111) begin
                if (k >= np || rv[i] != ~(3'b001 << c[2*k +: 2]) || rl[i] != P) ok = 0;
                if (k > 0 && (rv[i-1] != 3'b111 || rl[i-1] != G)) ok = 0;
                k++;
            end
        return ok && k == np;
    endfunction

    function automatic void ref_model(input logic [5:0] c, input bit nr, output bit p, output bit b, output int np);
        bit wrong = 0;
        b = 0;
        for (int i = 0; i < 3; i++) if (c[2*i +: 2] == 2'd3) b = 1;
        np = 0;
        if (!b && !nr)
            for (int i = 0; i < 3; i++) begin
                np = i + 1;
                if (c[2*i +: 2] != 2'(i)) begin wrong = 1; break; end
            end
        p = !b && !nr && !wrong;
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (btn !== 3'b111) begin n_fail++; $display("FAIL reset_btn: got %b required 111", btn); end
        n_tests++;
        if ({busy, done, pass, fail, bad_code} !== 5'b0) begin
            n_fail++; $display("FAIL reset_flags: busy/done/pass/fail/bad got %b required 00000", {busy, done, pass, fail, bad_code});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_correct;
        run_seq(6'b10_01_00, 0, 0);
        n_tests++;
        if ({pass, fail, bad_code} !== 3'b100) begin n_fail++; $display("FAIL correct_result: pass/fail/bad got %b required 100", {pass, fail, bad_code}); end
        n_tests++;
        if (trace_ok(6'b10_01_00, 3) !== 1'b1) begin n_fail++; $display("FAIL correct_trace: btn runs got %0d entries, required 110x4,111x4,101x4,111x4,011x4", rv.size()); end
        n_tests++;
        if (busy_drop !== 1'b0) begin n_fail++; $display("FAIL correct_busy: busy dropped got 1 required 0"); end
        @(posedge clk); #1;
        n_tests++;
        if ({done, pass} !== 2'b01) begin n_fail++; $display("FAIL correct_hold: done/pass got %b required 01", {done, pass}); end
    endtask

    task automatic test_wrong_second;
        run_seq(6'b10_00_00, 0, 0);
        n_tests++;
        if ({pass, fail, bad_code} !== 3'b010) begin n_fail++; $display("FAIL wrong2_result: pass/fail/bad got %b required 010", {pass, fail, bad_code}); end
        n_tests++;
        if (trace_ok(6'b10_00_00, 2) !== 1'b1) begin n_fail++; $display("FAIL wrong2_trace: btn runs got %0d entries, required exactly two presses", rv.size()); end
    endtask

    task automatic test_invalid;
        run_seq(6'b11_01_00, 0, 0);
        n_tests++;
        if (lat !== 2) begin n_fail++; $display("FAIL invalid_latency: got %0d required 2", lat); end
        n_tests++;
        if ({pass, fail, bad_code} !== 3'b011) begin n_fail++; $display("FAIL invalid_result: pass/fail/bad got %b required 011", {pass, fail, bad_code}); end
        n_tests++;
        if (trace_ok(6'b11_01_00, 0) !== 1'b1) begin n_fail++; $display("FAIL invalid_btn: got %0d btn runs required only 111", rv.size()); end
    endtask

    task automatic test_not_ready;
        run_seq(6'b10_01_00, 1, 0);
        n_tests++;
        if (lat !== T + 2) begin n_fail++; $display("FAIL notready_latency: got %0d required %0d", lat, T + 2); end
        n_tests++;
        if ({pass, fail, bad_code} !== 3'b010) begin n_fail++; $display("FAIL notready_result: pass/fail/bad got %b required 010", {pass, fail, bad_code}); end
        n_tests++;
        if (trace_ok(6'b10_01_00, 0) !== 1'b1) begin n_fail++; $display("FAIL notready_btn: got %0d btn runs required only 111", rv.size()); end
    endtask

    task automatic test_reset_mid_press;
        int n = 0;
        lock_rst = 1'b1;
        not_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        lock_rst = 1'b0;
        code = 6'b10_01_00;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (btn != 3'b110 && n < 20) begin @(posedge clk); #1; n++; end
        n_tests++;
        if (btn !== 3'b110) begin n_fail++; $display("FAIL midreset_press: btn got %b required 110", btn); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (btn !== 3'b111) begin n_fail++; $display("FAIL midreset_btn: got %b required 111", btn); end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b required 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        run_seq(6'b10_01_00, 0, 0);
        n_tests++;
        if ({pass, fail} !== 2'b10 || trace_ok(6'b10_01_00, 3) !== 1'b1) begin
            n_fail++; $display("FAIL midreset_rerun: pass/fail got %b required 10 with three clean presses", {pass, fail});
        end
    endtask

    task automatic test_busy_start;
        run_seq(6'b10_01_00, 0, 1);
        n_tests++;
        if ({pass, fail, bad_code} !== 3'b100) begin n_fail++; $display("FAIL busystart_result: pass/fail/bad got %b required 100", {pass, fail, bad_code}); end
        n_tests++;
        if (trace_ok(6'b10_01_00, 3) !== 1'b1) begin n_fail++; $display("FAIL busystart_trace: got %0d btn runs required three clean presses", rv.size()); end
    endtask

    task automatic test_back_to_back;
        run_seq(6'b10_01_00, 0, 0);
        code = 6'b00_00_11;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n_tests++;
        if ({busy, done, pass, bad_code} !== 4'b0010) begin
            n_fail++; $display("FAIL b2b_ignored: busy/done/pass/bad got %b required 0010", {busy, done, pass, bad_code});
        end
        run_seq(6'b00_00_11, 0, 0);
        n_tests++;
        if (lat !== 2 || {pass, fail, bad_code} !== 3'b011) begin
            n_fail++; $display("FAIL b2b_second: latency %0d pass/fail/bad %b required 2 and 011", lat, {pass, fail, bad_code});
        end
    endtask

    task automatic test_random;
        for (int it = 0; it < 24; it++) begin
            logic [5:0] c;
            bit nr, p, b;
            int np;
            c = 6'($urandom);
            if (it % 3 == 0) c = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 1)), 2'd0};
            nr = $urandom_range(0, 5) == 0;
            ref_model(c, nr, p, b, np);
            run_seq(c, nr, it % 2 == 1);
            n_tests++;
            if ({pass, fail, bad_code} !== {p, !p, b}) begin
                n_fail++; $display("FAIL rand_result code=%b nr=%0d: pass/fail/bad got %b required %b", c, nr, {pass, fail, bad_code}, {p, !p, b});
            end
            n_tests++;
            if (trace_ok(c, np) !== 1'b1) begin n_fail++; $display("FAIL rand_trace code=%b: got %0d btn runs required %0d presses", c, rv.size(), np); end
            n_tests++;
            if (busy_drop !== 1'b0) begin n_fail++; $display("FAIL rand_busy code=%b: busy dropped before done", c); end
            if (b || nr) begin
                n_tests++;
                if (lat !== (b ? 2 : T + 2)) begin n_fail++; $display("FAIL rand_latency code=%b: got %0d required %0d", c, lat, b ? 2 : T + 2); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_correct;
        test_wrong_second;
        test_invalid;
        test_not_ready;
        test_reset_mid_press;
        test_busy_start;
        test_back_to_back;
        test_random;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/safecrack_dialer.md
# safecrack_dialer

Automatic code-entry driver for the safe-cracking lock FSM. It replays a 3-digit button sequence onto the lock's active-low button inputs, with press and release timing. It then watches the lock's LED outputs and reports pass or fail. It sits between a host (self-test or demo controller) and the lock, in place of the physical push-buttons.

## Interface
- `PRESS_CYCLES`, default 500_000: clocks each button is held low (10 ms at 50 MHz).
- `GAP_CYCLES`, default 500_000: clocks all buttons stay released between digits.
- `TIMEOUT_CYCLES`, default 1_000_000: maximum wait for lock-ready and for the final result.
- `clk`  in  1  system clock. One clock domain; the lock runs on the same clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  pulse that begins a dial sequence. Ignored while `busy`.
- `code`  in  6  digits; digit i = `code[2i+1:2i]`, value = button index 0..2. Value 3 is invalid.
- `leds_green`  in  8  lock progress LEDs.
- `led_red`  in  1  lock error LED.
- `btn`  out  3  button drive to the lock, active-low. Idle value is 3'b111.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse when a sequence ends.
- `pass`  out  1  result flag, valid from `done` until the next accepted `start`.
- `fail`  out  1  result flag, valid from `done` until the next accepted `start`.
- `bad_code`  out  1  set together with `fail` when the latched code contains a 3.

## Operation
- States: IDLE, WAIT_READY, PRESS, GAP, CHECK, DONE.
- IDLE:
  - On `start`, latch `code` and clear `pass`, `fail` and `bad_code`.
  - If any digit equals 3, go to DONE with `fail=1` and `bad_code=1`. No button activity occurs.
  - Otherwise load the timer with TIMEOUT_CYCLES and go to WAIT_READY.
- WAIT_READY:
  - When `leds_green==8'h01` and `!led_red`, set digit index to 0, load the timer with PRESS_CYCLES and go to PRESS.
  - If the timer expires first, go to DONE with `fail=1`.
- PRESS:
  - `btn[digit]=0`; all other `btn` bits are 1.
  - When the timer expires, load GAP_CYCLES and go to GAP.
- GAP:
  - `btn=3'b111`.
  - If `led_red` is seen at any cycle, abort to DONE with `fail=1`.
  - On timer expiry:
    - if index<2, increment the index, load PRESS_CYCLES and go to PRESS;
    - otherwise load TIMEOUT_CYCLES and go to CHECK.
- CHECK:
  - `leds_green==8'hFF` → DONE with `pass=1`.
  - `led_red` → DONE with `fail=1`.
  - Timer expiry → DONE with `fail=1`.
  - If both LED conditions hold in the same cycle, `fail` wins.
- DONE: pulse `done` for one cycle, then return to IDLE. `pass`, `fail` and `bad_code` hold their values.
- The timer is a down-counter with width `$clog2` of the largest parameter, plus 1. "Expires" means the counter reads 0.

## Timing
- Reset values: state=IDLE, `btn=3'b111`, `busy=0`, `done=0`, `pass=0`, `fail=0`, `bad_code=0`, timer=0, index=0.
- Reset is asynchronous and may assert mid-sequence. `btn` returns to 3'b111 immediately, so the lock sees a release and no spurious press.
- All outputs are registered.
- `start` is sampled at the rising edge T. `busy=1` from T+1.
- With a bad code, `done` pulses at T+2.
- Each press holds `btn` low for exactly PRESS_CYCLES consecutive cycles. Each gap holds `btn` high for exactly GAP_CYCLES cycles.
- `start` arriving in the same cycle as `done` is ignored. A new `start` is accepted only in IDLE.
- LED inputs are used as-is, because they come from the lock's combinational outputs on the same clock. No synchroniser is required.

## Structure
- Shared package `safecrack_pkg` holds:
  - `dial_state_t` enum (one-hot, matching the lock FSM's encoding style);
  - `LED_READY=8'h01`;
  - `LED_SUCCESS=8'hFF`;
  - `BTN_IDLE=3'b111`;
  - `DIGITS=3`.
- One sub-module, `safecrack_timer`: a loadable down-counter with an expired flag. It is also reusable by the lock.

## Test plan
Use PRESS=4, GAP=4, TIMEOUT=20 against a behavioural lock model with correct code 0,1,2.
- Correct code: `code=6'b10_01_00`, start → `btn` goes 110 for 4 cycles, then 111, then 101, then 011. Lock shows 8'hFF → `done` pulse, `pass=1`, `fail=0`.
- Wrong second digit: `code=6'b10_00_00` → lock raises `led_red` during GAP after digit 1 → `fail=1`. No third press occurs.
- Invalid code: `code=6'b11_01_00` → `done` at T+2, `fail=1`, `bad_code=1`, `btn` stays 111 throughout.
- Lock not ready: `leds_green` held at 8'h00 → `done` after 20 cycles in WAIT_READY, `fail=1`.
- Reset during PRESS: assert `rst` while `btn=110` → `btn=111` and `busy=0` in the same cycle. A following start runs normally.
- `start` pulses while `busy` → ignored. The result reflects only the first sequence.
